// File: rtl/maze_grid_receiver_pkg.sv
// rtl/maze_grid_receiver_pkg.sv - shared types and constants for the maze grid receiver
// Purpose: default grid size, cell encodings, packet field positions, receiver FSM states.
// Ports: none (package).
package maze_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 5;

  // Renderer colours: EMPTY black, VISITED blue, WALL green, ROBOT red.
  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'd0,
    CELL_VISITED = 2'd1,
    CELL_WALL    = 2'd2,
    CELL_ROBOT   = 2'd3
  } cell_e;

  // Packet byte layout: [7:6] row, [5:3] col, [2:1] state, [0] even parity.
  localparam int ROW_MSB = 7;
  localparam int ROW_LSB = 6;
  localparam int COL_MSB = 5;
  localparam int COL_LSB = 3;
  localparam int ST_MSB  = 2;
  localparam int ST_LSB  = 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_e;

  // True when the byte holds an even number of ones.
  function automatic logic parity_even(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/maze_grid_receiver_if.sv
// rtl/maze_grid_receiver_if.sv - 3-wire serial link from the robot's Arduino
// Purpose: groups the serial link wires.
// Ports: SCLK_IN serial clock, SDATA_IN serial data (MSB first), CS_N_IN packet frame.
// master = Arduino side (drives), slave = receiver side.
interface maze_grid_receiver_if;
  logic SCLK_IN;
  logic SDATA_IN;
  logic CS_N_IN;

  modport master (output SCLK_IN, output SDATA_IN, output CS_N_IN);
  modport slave  (input  SCLK_IN, input  SDATA_IN, input  CS_N_IN);
endinterface

// File: rtl/maze_grid_receiver_sync_edge.sv
// rtl/maze_grid_receiver_sync_edge.sv - N-stage synchronizer with rise/fall detect
// Purpose: brings one asynchronous input into the clock domain and flags its edges.
// Ports: clk, rst_n (async active-low), async_in (raw pin), sync_out (synchronized level),
//        rise/fall (one-cycle pulses, high while sync_out differs from its delayed copy).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Reset to 0 on every input so that reset release never fakes an edge on a low pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_out = chain_q[STAGES-1];
  assign rise     = chain_q[STAGES-1] & ~prev_q;
  assign fall     = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/maze_grid_receiver.sv
// rtl/maze_grid_receiver.sv - serial maze-cell packet receiver and grid store
// Purpose: receives 8-bit cell update packets, validates them and keeps a ROWS x COLS
//          grid of 2-bit cell states for the VGA pixel mapper.
// Ports: CLOCK, RESET_N (async active-low); link (serial link, slave modport);
//        RD_ROW/RD_COL -> RD_DATA combinational read port (0 when out of range);
//        GRID_FLAT whole grid; PKT_OK/PKT_ERR one-cycle result pulses;
//        ERR_COUNT saturating reject count; LAST_PKT last accepted byte.
module maze_grid_receiver
  import maze_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int TIMEOUT     = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  maze_grid_receiver_if.slave      link,
  input  logic [1:0]               RD_ROW,
  input  logic [2:0]               RD_COL,
  output logic [1:0]               RD_DATA,
  output logic [2*ROWS*COLS-1:0]   GRID_FLAT,
  output logic                     PKT_OK,
  output logic                     PKT_ERR,
  output logic [7:0]               ERR_COUNT,
  output logic [7:0]               LAST_PKT
);

  localparam int TW = $clog2(TIMEOUT);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic sdata_level, sdata_rise, sdata_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(CLOCK), .rst_n(RESET_N), .async_in(link.CS_N_IN),
    .sync_out(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(CLOCK), .rst_n(RESET_N), .async_in(link.SCLK_IN),
    .sync_out(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(CLOCK), .rst_n(RESET_N), .async_in(link.SDATA_IN),
    .sync_out(sdata_level), .rise(sdata_rise), .fall(sdata_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_level, sclk_fall, sdata_rise, sdata_fall};

  rx_state_e             state_q, state_n;
  logic [7:0]            shift_q;
  logic [3:0]            bit_cnt_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  timeout_q;
  logic                  armed_q;
  logic [2*ROWS*COLS-1:0] grid_q;

  logic       to_hit;
  logic       start;
  logic       accept;
  logic [1:0] pkt_row;
  logic [2:0] pkt_col;
  logic [1:0] pkt_state;
  int         wr_idx;

  // After reset the link is ignored until CS_N has been seen high, so a packet
  // already in flight at release is never picked up half-way.
  assign start  = cs_fall & armed_q;
  assign to_hit = (to_cnt_q == TW'(TIMEOUT - 1));

  assign pkt_row   = shift_q[ROW_MSB:ROW_LSB];
  assign pkt_col   = shift_q[COL_MSB:COL_LSB];
  assign pkt_state = shift_q[ST_MSB:ST_LSB];

  always_comb begin
    accept = (bit_cnt_q == 4'd8) && parity_even(shift_q) &&
             (int'(pkt_row) < ROWS) && (int'(pkt_col) < COLS) && !timeout_q;
    wr_idx = int'(pkt_row) * COLS + int'(pkt_col);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= RX_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RX_IDLE:  if (start) state_n = RX_SHIFT;
      RX_SHIFT: if (cs_rise || to_hit) state_n = RX_CHECK;
      RX_CHECK: state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
      grid_q    <= '0;
      PKT_OK    <= 1'b0;
      PKT_ERR   <= 1'b0;
      ERR_COUNT <= '0;
      LAST_PKT  <= '0;
    end else begin
      PKT_OK  <= 1'b0;
      PKT_ERR <= 1'b0;
      if (cs_level) armed_q <= 1'b1;

      unique case (state_q)
        RX_IDLE: begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          timeout_q <= 1'b0;
          if (start) shift_q <= '0;
        end
        RX_SHIFT: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          if (to_hit) timeout_q <= 1'b1;
          // A clock edge coinciding with the end of frame is not part of the packet.
          if (sclk_rise && !cs_rise && !to_hit) begin
            shift_q <= {shift_q[6:0], sdata_level};
            if (bit_cnt_q != 4'd9) bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        RX_CHECK: begin
          if (accept) begin
            grid_q[2*wr_idx +: 2] <= pkt_state;
            LAST_PKT              <= shift_q;
            PKT_OK                <= 1'b1;
          end else begin
            PKT_ERR <= 1'b1;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign GRID_FLAT = grid_q;

  // Combinational read: a write landing this cycle shows up on the next one.
  int   rd_idx;
  logic rd_hit;
  always_comb begin
    rd_idx  = 0;
    rd_hit  = 1'b0;
    RD_DATA = 2'b00;
    if ((int'(RD_ROW) < ROWS) && (int'(RD_COL) < COLS)) begin
      rd_hit = 1'b1;
      rd_idx = int'(RD_ROW) * COLS + int'(RD_COL);
    end
    if (rd_hit) RD_DATA = grid_q[2*rd_idx +: 2];
  end

endmodule

// File: tb/tb_maze_grid_receiver.sv
// tb/tb_maze_grid_receiver.sv - self-checking bench for maze_grid_receiver
module tb_maze_grid_receiver;

  localparam int ROWS    = 4;
  localparam int COLS    = 5;
  localparam int TIMEOUT = 25000;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 2;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic [1:0]  RD_ROW;
  logic [2:0]  RD_COL;
  logic [1:0]  RD_DATA;
  logic [39:0] GRID_FLAT;
  logic        PKT_OK;
  logic        PKT_ERR;
  logic [7:0]  ERR_COUNT;
  logic [7:0]  LAST_PKT;

  maze_grid_receiver_if link();

  maze_grid_receiver #(
    .ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .link(link),
    .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_DATA(RD_DATA),
    .GRID_FLAT(GRID_FLAT), .PKT_OK(PKT_OK), .PKT_ERR(PKT_ERR),
    .ERR_COUNT(ERR_COUNT), .LAST_PKT(LAST_PKT)
  );

  always #20 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Spec-level model: grid contents, counters, expected pulse totals.
  logic [1:0] mgrid [ROWS][COLS];
  int         merr;
  logic [7:0] mlast;
  int         exp_ok, exp_err;
  int         ok_seen = 0, err_seen = 0;
  bit         settled = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mgrid[r][c] = 2'd0;
    merr  = 0;
    mlast = 8'h00;
  endtask

  task automatic model_apply(input logic [15:0] bits, input int n, input bit timed_out);
    logic [7:0] b;
    b = bits[7:0];
    if (!timed_out && n == 8 && ($countones(b) % 2 == 0) &&
        int'(b[7:6]) < ROWS && int'(b[5:3]) < COLS) begin
      mgrid[b[7:6]][b[5:3]] = b[2:1];
      mlast = b;
      exp_ok++;
    end else begin
      exp_err++;
      if (merr < 255) merr++;
    end
  endtask

  function automatic logic [39:0] model_flat();
    logic [39:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) f[2*(r*COLS+c) +: 2] = mgrid[r][c];
    return f;
  endfunction

  function automatic logic [1:0] model_rd(input logic [1:0] r, input logic [2:0] c);
    if (int'(r) < ROWS && int'(c) < COLS) return mgrid[r][c];
    return 2'd0;
  endfunction

  // Pulse counter, active for the whole run.
  always @(negedge CLOCK) begin
    if (PKT_OK === 1'b1)  ok_seen++;
    if (PKT_ERR === 1'b1) err_seen++;
  end

  // Per-cycle comparison against the model whenever the link is quiet.
  always @(negedge CLOCK) begin
    if (settled) begin
      check("grid_flat", GRID_FLAT, model_flat());
      check("rd_data", RD_DATA, model_rd(RD_ROW, RD_COL));
      check("err_count", ERR_COUNT, merr);
      check("last_pkt", LAST_PKT, mlast);
      check("pkt_ok_quiet", PKT_OK, 1'b0);
      check("pkt_err_quiet", PKT_ERR, 1'b0);
      check("ok_pulses", ok_seen, exp_ok);
      check("err_pulses", err_seen, exp_err);
    end
  end

  // Read-port sweep, including out-of-range columns 5..7.
  initial begin
    RD_ROW = 2'd0;
    RD_COL = 3'd0;
    forever begin
      @(posedge CLOCK);
      #1;
      {RD_ROW, RD_COL} = {RD_ROW, RD_COL} + 5'd1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      link.SDATA_IN = bits[i];
      tick(2);
      link.SCLK_IN = 1'b1;
      tick(2);
      link.SCLK_IN = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [15:0] bits, input int n, input int gap);
    settled = 0;
    link.CS_N_IN = 1'b0;
    tick(3);
    send_bits(bits, n);
    tick(2);
    link.CS_N_IN = 1'b1;
    tick(gap);
    model_apply(bits, n, 1'b0);
  endtask

  task automatic send_settle(input logic [15:0] bits, input int n);
    send_pkt(bits, n, 8);
    settled = 1;
    tick(2);
  endtask

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_ok, first_err, e0;
    model_reset();
    exp_ok  = 0;
    exp_err = 0;
    RESET_N = 1'b0;
    link.CS_N_IN  = 1'b1;
    link.SCLK_IN  = 1'b0;
    link.SDATA_IN = 1'b0;
    tick(2);
    @(negedge CLOCK);
    check("rst_grid", GRID_FLAT, 40'h0);
    check("rst_ok", PKT_OK, 1'b0);
    check("rst_err", PKT_ERR, 1'b0);
    check("rst_err_count", ERR_COUNT, 8'h00);
    check("rst_last", LAST_PKT, 8'h00);
    RESET_N = 1'b1;
    tick(4);
    settled = 1;
    tick(4);

    // 0x56: row 1, col 2, ROBOT, with latency measured from the CS_N rise.
    settled = 0;
    link.CS_N_IN = 1'b0;
    tick(3);
    send_bits(16'h56, 8);
    tick(2);
    link.CS_N_IN = 1'b1;
    first_ok = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK);
      if (PKT_OK === 1'b1 && first_ok < 0) first_ok = k;
      if (k == LAT - 1) check("grid_before_write", GRID_FLAT, 40'h0);
      if (k == LAT)     check("grid_after_write", GRID_FLAT, 40'h00_0000_C000);
      @(posedge CLOCK);
    end
    #1;
    check("ok_latency", first_ok, LAT);
    model_apply(16'h56, 8, 1'b0);
    settled = 1;
    tick(2);
    check("cell_1_2", GRID_FLAT[15:14], 2'd3);
    check("last_56", LAST_PKT, 8'h56);

    // Rejections: bad parity, column out of range, short and long packets.
    send_settle(16'h57, 8);
    check("err_after_parity", ERR_COUNT, 8'd1);
    check("last_kept", LAST_PKT, 8'h56);
    send_settle(16'h2B, 8);
    send_settle(16'h2B, 7);
    send_settle(16'h056, 9);
    check("err_after_len", ERR_COUNT, 8'd4);
    check("grid_kept", GRID_FLAT, 40'h00_0000_C000);

    // CS_N held low with no clock: one timeout reject, TIMEOUT cycles into the frame.
    settled = 0;
    e0 = err_seen;
    first_err = -1;
    link.CS_N_IN = 1'b0;
    for (int k = 0; k < TIMEOUT + 10; k++) begin
      @(negedge CLOCK);
      if (PKT_ERR === 1'b1 && first_err < 0) first_err = k;
      @(posedge CLOCK);
    end
    #1;
    check("timeout_pulses", err_seen - e0, 1);
    check("timeout_at", first_err, TIMEOUT + LAT);
    model_apply(16'h0, 0, 1'b1);
    link.CS_N_IN = 1'b1;
    tick(8);
    settled = 1;
    tick(2);
    send_settle(16'h56, 8);
    check("after_timeout_ok", ok_seen, 2);

    // Reset in the middle of a packet, then a fresh VISITED write to (0,0).
    settled = 0;
    link.CS_N_IN = 1'b0;
    tick(3);
    send_bits(16'h5, 4);
    RESET_N = 1'b0;
    tick(3);
    model_reset();
    RESET_N = 1'b1;
    tick(5);
    link.CS_N_IN = 1'b1;
    tick(6);
    settled = 1;
    tick(2);
    send_settle(16'h03, 8);
    check("reset_grid", GRID_FLAT, 40'h00_0000_0001);
    check("reset_err_count", ERR_COUNT, 8'd0);

    // 300 rejects saturate the counter.
    for (int i = 0; i < 300; i++) send_pkt(16'h57, 8, 6);
    settled = 1;
    tick(2);
    check("err_saturated", ERR_COUNT, 8'd255);

    // Back-to-back writes to (0,0): VISITED, WALL, ROBOT; the last one stays.
    send_pkt(16'h03, 8, 4);
    send_pkt(16'h05, 8, 4);
    send_pkt(16'h06, 8, 8);
    settled = 1;
    tick(2);
    check("last_wins", GRID_FLAT[1:0], 2'd3);
    check("last_wins_pkt", LAST_PKT, 8'h06);
    tick(40);
    settled = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
